// File: rtl/prog_mem_reader.sv
// Memory readback engine: streams an inclusive, possibly wrapping, address range
// from a 1-cycle-latency read port out over valid/ready, tagged with address and last flag.
module prog_mem_reader #(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_SIZE  = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] start_addr,
  input  logic [ADDR_SIZE-1:0] end_addr,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [DATA_SIZE-1:0] mem_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [ADDR_SIZE-1:0] out_addr,
  output logic                 out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int RW = ADDR_SIZE + 1;
  localparam logic [CW:0]   DEPTH_L = CW1'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic                 last;
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  logic [1:0]           state;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE-1:0] last_addr;
  logic [ADDR_SIZE-1:0] span;
  logic [RW-1:0]        remaining;
  logic                 inflight;
  logic [ADDR_SIZE-1:0] inf_addr;
  logic                 inf_last;

  entry_t [FIFO_DEPTH-1:0] fifo_q;
  entry_t                  head;
  logic [PW-1:0]           wr_idx;
  logic [PW-1:0]           rd_idx;
  logic [CW-1:0]           occ;

  logic          kill;
  logic          pop;
  logic [CW:0]   fill;
  logic [CW:0]   cap;

  function automatic logic [PW-1:0] idx_nxt(input logic [PW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign kill = abort && (state != S_IDLE);
  assign span = end_addr - start_addr;
  assign head = fifo_q[rd_idx];

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head.data : '0;
  assign out_addr  = out_valid ? head.addr : '0;
  assign out_last  = out_valid && head.last;

  // Issue only if the word is guaranteed a FIFO slot when it lands next cycle.
  assign fill = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign cap  = DEPTH_L + {{CW{1'b0}}, pop};
  assign mem_rd_en = (state == S_READ) && !abort && (remaining != '0) && (fill < cap);
  assign mem_addr  = mem_rd_en ? rd_ptr : last_addr;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      last_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      inf_addr  <= '0;
      inf_last  <= 1'b0;
      fifo_q    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      occ       <= '0;
    end else if (kill) begin
      // Anything already read or in flight is dropped; no done pulse.
      state     <= S_IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      occ       <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) begin
        inf_addr  <= rd_ptr;
        inf_last  <= (remaining == RW'(1));
        last_addr <= rd_ptr;
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      if (inflight) begin
        fifo_q[wr_idx] <= {inf_last, inf_addr, mem_rd_data};
        wr_idx         <= idx_nxt(wr_idx);
      end
      if (pop) rd_idx <= idx_nxt(rd_idx);

      case ({inflight, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            rd_ptr    <= start_addr;
            remaining <= {1'b0, span} + RW'(1);
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (mem_rd_en && (remaining == RW'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Leave once the word being popped now is the last one held.
          if (!inflight && (occ == CW'(pop))) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
